pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Parametrised program-counter sequencer for the MIPS datapath: holds the PC register, forms the sequential, branch and jump targets, and keeps a small return-address stack (RAS) so `jal`/`jr $ra` pairs resolve without a register-file read. It sits at the front of instruction fetch. It replaces the separate PC register, adder and jump-address concatenation logic with one stallable block.

## Interface
Parameters:
- `ADDR_W`, 32, PC width in bits; must be ≥ 28.
- `RESET_PC`, 0, PC value loaded on reset; bits [1:0] must be 0.
- `RAS_DEPTH`, 4, number of return-address stack entries; power of two, ≥ 2.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `stall`  in  1  hold PC and RAS this cycle.
- `branch_taken`  in  1  conditional branch resolved taken.
- `branch_offset`  in  16  signed word offset (instruction imm16).
- `jump`  in  1  `j` instruction.
- `call`  in  1  `jal` instruction: jump and push return address.
- `jump_index`  in  26  instr_index field for `j`/`jal`.
- `ret`  in  1  `jr $ra`: pop RAS.
- `jr_target`  in  ADDR_W  register-file value, used for `ret` when the RAS is empty.
- `pc`  out  ADDR_W  current PC (registered).
- `pc_plus4`  out  ADDR_W  `pc + 4`, combinational.
- `ras_empty`  out  1  RAS holds 0 entries.
- `ras_full`  out  1  RAS holds `RAS_DEPTH` entries.
- `ras_overflow`  out  1  sticky: a push was made while full.
- `ras_underflow`  out  1  sticky: a pop was made while empty.

## Operation
- `pc_plus4 = pc + 4`, modulo 2^ADDR_W.
- Branch target: `pc_plus4 + (sign_extend(branch_offset) << 2)`, truncated to ADDR_W.
- Jump target: `{pc_plus4[ADDR_W-1:28], jump_index, 2'b00}`.
- Return target: RAS top entry if not empty, else `jr_target`.
- Next-PC priority (highest first): `reset` → `RESET_PC`; `stall` → hold; `ret`; `jump` or `call`; `branch_taken`; otherwise `pc_plus4`.
- A lower-priority request asserted in the same cycle as a higher one is ignored completely, including its RAS effect. The one exception is `ret` together with `call`, covered below.
- RAS is a circular buffer with a top pointer and an occupancy count of 0..`RAS_DEPTH`.
- `call` (not stalled, no `ret`) pushes `pc_plus4`.
  - If the RAS is full, the oldest entry is overwritten, the count stays at `RAS_DEPTH`, and `ras_overflow` is set.
- `ret` (not stalled, no `call`) pops when the count is > 0.
  - If the count is 0, the PC takes `jr_target`, the count stays 0, and `ras_underflow` is set.
- `ret` and `call` in the same cycle: the PC takes the return target. The top entry is replaced by `pc_plus4` and the count is unchanged.
  - If the RAS is empty, `pc_plus4` is pushed and the count becomes 1.
- `jump` and `call` together behave as `call`.
- The sticky flags clear only on `reset`.

## Timing
- Reset values: `pc = RESET_PC`, RAS count 0, `ras_empty = 1`, `ras_full = 0`, `ras_overflow = 0`, `ras_underflow = 0`. RAS entry contents are don't-care.
- Latency: control inputs sampled at edge N set `pc` visible after edge N. There is one cycle from decision to new PC.
- `ras_empty` and `ras_full` are derived from the registered count and are valid in the cycle after the updating edge.
- `reset` asserted mid-sequence, including during `stall`, overrides everything on that edge.
- `stall` freezes all state, including the sticky flags; inputs in a stalled cycle have no effect.
- `pc_plus4` and the targets are combinational from `pc` and the inputs; the only registers are the PC, the RAS, the count/pointer and the flags.

## Test plan
- Reset, then 3 idle cycles → `pc` reads 0x0, 0x4, 0x8, 0xC; `ras_empty = 1`.
- At `pc = 0x0040_0010`: `branch_taken` with offset 0xFFFC → next `pc = 0x0040_0004`. With `jump = 1` and `jump_index = 0x0100000` in the same cycle → next `pc = 0x0040_0000` (jump wins, branch ignored).
- At `pc = 0x0040_0000`: `call` with index 0x0100010 → `pc = 0x0040_0040`, RAS top 0x0040_0004. Three idle cycles, then `ret` → `pc = 0x0040_0004`, `ras_empty = 1`.
- `RAS_DEPTH = 4`, five nested calls → `ras_full = 1`, `ras_overflow = 1`. Five rets → first four return the 5th, 4th, 3rd and 2nd return addresses in order. The fifth uses `jr_target = 0x1234_5678` and sets `ras_underflow`.
- `stall` held for 2 cycles while `call` is asserted → `pc` and RAS unchanged. On release, `call` takes effect on the next edge.
- `ret` and `call` together with top entry 0x0040_0100 at `pc = 0x0040_0200` → `pc = 0x0040_0100`, top becomes 0x0040_0204, count unchanged. Then `reset` mid-sequence → `pc = RESET_PC`, all flags 0.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer
// Program-counter sequencer for the front of MIPS instruction fetch. Holds the
// PC register, forms sequential / branch / jump targets and keeps a small
// circular return-address stack so jal / jr $ra pairs resolve without a
// register-file read. Everything is stallable.
//
// Parameters:
//   ADDR_W     PC width in bits (>= 28)
//   RESET_PC   PC loaded on reset (word aligned)
//   RAS_DEPTH  number of RAS entries (power of two, >= 2)
//
// Ports:
//   clk, reset       clock and synchronous active-high reset
//   stall            hold PC, RAS and flags this cycle
//   branch_taken     conditional branch resolved taken, with branch_offset (imm16)
//   jump             j instruction, target from jump_index
//   call             jal instruction: jump and push return address
//   ret              jr $ra: pop RAS, falls back to jr_target when empty
//   pc, pc_plus4     registered PC and its sequential successor
//   ras_empty/full   occupancy status of the RAS
//   ras_overflow     sticky: push made while full
//   ras_underflow    sticky: pop made while empty
module pc_sequencer #(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter int                RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [15:0]       branch_offset,
  input  logic              jump,
  input  logic              call,
  input  logic [25:0]       jump_index,
  input  logic              ret,
  input  logic [ADDR_W-1:0] jr_target,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic              ras_empty,
  output logic              ras_full,
  output logic              ras_overflow,
  output logic              ras_underflow
);

  localparam int             PTR_W    = $clog2(RAS_DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(RAS_DEPTH);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] ras_q [RAS_DEPTH];
  logic [ADDR_W-1:0] ras_d [RAS_DEPTH];
  logic [PTR_W-1:0]  top_q, top_d;
  logic [PTR_W:0]    count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;

  logic [ADDR_W-1:0] branch_target;
  logic [ADDR_W-1:0] jump_target;
  logic [ADDR_W-1:0] ret_target;
  logic [PTR_W-1:0]  top_inc;
  logic [PTR_W-1:0]  top_dec;
  logic              ras_wr;
  logic [PTR_W-1:0]  ras_wr_idx;

  assign pc            = pc_q;
  assign pc_plus4      = pc_q + ADDR_W'(4);
  assign ras_empty     = (count_q == '0);
  assign ras_full      = (count_q == FULL_CNT);
  assign ras_overflow  = overflow_q;
  assign ras_underflow = underflow_q;

  // Word offset, sign extended and scaled to a byte offset.
  assign branch_target = pc_plus4 + {{(ADDR_W-18){branch_offset[15]}}, branch_offset, 2'b00};

  // The region bits above bit 27 only exist when the PC is wider than 28 bits.
  generate
    if (ADDR_W > 28) begin : g_jump_region
      assign jump_target = {pc_plus4[ADDR_W-1:28], jump_index, 2'b00};
    end else begin : g_jump_flat
      assign jump_target = {jump_index, 2'b00};
    end
  endgenerate

  assign ret_target = ras_empty ? jr_target : ras_q[top_q];

  // Pointer arithmetic wraps naturally because the depth is a power of two.
  assign top_inc = top_q + PTR_W'(1);
  assign top_dec = top_q - PTR_W'(1);

  // Next-state selection. Priority is stall, ret, jump/call, branch, sequential.
  // When full, top_inc lands on the oldest entry, so a push overwrites it.
  always_comb begin
    pc_d        = pc_q;
    top_d       = top_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    ras_wr      = 1'b0;
    ras_wr_idx  = top_q;
    if (!stall) begin
      if (ret) begin
        pc_d = ret_target;
        if (call) begin
          // ret+call swaps the top entry; an empty stack just receives a push.
          ras_wr = 1'b1;
          if (ras_empty) begin
            ras_wr_idx = top_inc;
            top_d      = top_inc;
            count_d    = (PTR_W+1)'(1);
          end else begin
            ras_wr_idx = top_q;
          end
        end else if (ras_empty) begin
          underflow_d = 1'b1;
        end else begin
          top_d   = top_dec;
          count_d = count_q - (PTR_W+1)'(1);
        end
      end else if (jump || call) begin
        pc_d = jump_target;
        if (call) begin
          ras_wr     = 1'b1;
          ras_wr_idx = top_inc;
          top_d      = top_inc;
          if (ras_full) begin
            overflow_d = 1'b1;
          end else begin
            count_d = count_q + (PTR_W+1)'(1);
          end
        end
      end else if (branch_taken) begin
        pc_d = branch_target;
      end else begin
        pc_d = pc_plus4;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < RAS_DEPTH; i++) begin
      ras_d[i] = ras_q[i];
    end
    if (ras_wr) begin
      ras_d[ras_wr_idx] = pc_plus4;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q        <= RESET_PC;
      top_q       <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      top_q       <= top_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Entry contents are don't-care after reset, so the storage has no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < RAS_DEPTH; i++) begin
      ras_q[i] <= ras_d[i];
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer
// Directed bench for pc_sequencer (ADDR_W=32, RESET_PC=0, RAS_DEPTH=4).
// Each step drives inputs, pushes the expected post-edge state onto a
// scoreboard queue, clocks once and pops/compares against the DUT outputs.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [15:0] branch_offset;
  logic        jump;
  logic        call;
  logic [25:0] jump_index;
  logic        ret;
  logic [31:0] jr_target;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        ras_empty;
  logic        ras_full;
  logic        ras_overflow;
  logic        ras_underflow;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic        empty;
    logic        full;
    logic        ovf;
    logic        unf;
  } exp_t;

  exp_t sb_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  pc_sequencer #(
    .ADDR_W   (32),
    .RESET_PC (32'h0),
    .RAS_DEPTH(4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_offset(branch_offset),
    .jump         (jump),
    .call         (call),
    .jump_index   (jump_index),
    .ret          (ret),
    .jr_target    (jr_target),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .ras_empty    (ras_empty),
    .ras_full     (ras_full),
    .ras_overflow (ras_overflow),
    .ras_underflow(ras_underflow)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic clear_inputs();
    reset         = 1'b0;
    stall         = 1'b0;
    branch_taken  = 1'b0;
    branch_offset = 16'h0;
    jump          = 1'b0;
    call          = 1'b0;
    jump_index    = 26'h0;
    ret           = 1'b0;
    jr_target     = 32'h0;
  endtask

  task automatic compare32(string name, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", name, obs, exp);
    end
  endtask

  task automatic compare1(string name, logic obs, logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %b expected %b", name, obs, exp);
    end
  endtask

  task automatic check_output();
    exp_t e;
    if (sb_q.size() == 0) begin
      vectors++;
      miscompares++;
      $error("[TB] FAIL scoreboard: observed empty queue expected an entry");
    end else begin
      e = sb_q.pop_front();
      compare32({e.tag, ".pc"}, pc, e.pc);
      compare32({e.tag, ".pc_plus4"}, pc_plus4, e.pc + 32'd4);
      compare1({e.tag, ".ras_empty"}, ras_empty, e.empty);
      compare1({e.tag, ".ras_full"}, ras_full, e.full);
      compare1({e.tag, ".ras_overflow"}, ras_overflow, e.ovf);
      compare1({e.tag, ".ras_underflow"}, ras_underflow, e.unf);
    end
  endtask

  // Inputs are already set by the caller; record the expectation, take one
  // edge, sample 1ns later, then return inputs to idle.
  task automatic apply_stimulus(string tag, logic [31:0] epc, logic ee, logic ef,
                                logic eo, logic eu);
    exp_t e;
    e.tag   = tag;
    e.pc    = epc;
    e.empty = ee;
    e.full  = ef;
    e.ovf   = eo;
    e.unf   = eu;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    check_output();
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    apply_stimulus("reset", 32'h0, 1, 0, 0, 0);
    for (int i = 1; i <= 3; i++) begin
      apply_stimulus("idle", 32'(i * 4), 1, 0, 0, 0);
    end

    jump = 1'b1; jump_index = 26'h0100004;
    apply_stimulus("jump_a", 32'h0040_0010, 1, 0, 0, 0);
    branch_taken = 1'b1; branch_offset = 16'hFFFC;
    apply_stimulus("branch_back", 32'h0040_0004, 1, 0, 0, 0);
    jump = 1'b1; jump_index = 26'h0100004;
    apply_stimulus("jump_b", 32'h0040_0010, 1, 0, 0, 0);
    branch_taken = 1'b1; branch_offset = 16'hFFFC; jump = 1'b1; jump_index = 26'h0100000;
    apply_stimulus("jump_over_branch", 32'h0040_0000, 1, 0, 0, 0);

    call = 1'b1; jump_index = 26'h0100010;
    apply_stimulus("call", 32'h0040_0040, 0, 0, 0, 0);
    apply_stimulus("idle_c1", 32'h0040_0044, 0, 0, 0, 0);
    apply_stimulus("idle_c2", 32'h0040_0048, 0, 0, 0, 0);
    apply_stimulus("idle_c3", 32'h0040_004C, 0, 0, 0, 0);
    ret = 1'b1;
    apply_stimulus("ret", 32'h0040_0004, 1, 0, 0, 0);

    // Five nested calls; the stalled call in between must not set overflow.
    call = 1'b1; jump_index = 26'h0100400;
    apply_stimulus("nest1", 32'h0040_1000, 0, 0, 0, 0);
    call = 1'b1; jump_index = 26'h0100800;
    apply_stimulus("nest2", 32'h0040_2000, 0, 0, 0, 0);
    call = 1'b1; jump_index = 26'h0100C00;
    apply_stimulus("nest3", 32'h0040_3000, 0, 0, 0, 0);
    call = 1'b1; jump_index = 26'h0101000;
    apply_stimulus("nest4", 32'h0040_4000, 0, 1, 0, 0);
    stall = 1'b1; call = 1'b1; jump_index = 26'h0101400;
    apply_stimulus("stall_full", 32'h0040_4000, 0, 1, 0, 0);
    call = 1'b1; jump_index = 26'h0101400;
    apply_stimulus("nest5", 32'h0040_5000, 0, 1, 1, 0);
    ret = 1'b1;
    apply_stimulus("unwind1", 32'h0040_4004, 0, 0, 1, 0);
    ret = 1'b1;
    apply_stimulus("unwind2", 32'h0040_3004, 0, 0, 1, 0);
    ret = 1'b1;
    apply_stimulus("unwind3", 32'h0040_2004, 0, 0, 1, 0);
    ret = 1'b1;
    apply_stimulus("unwind4", 32'h0040_1004, 1, 0, 1, 0);
    ret = 1'b1; jr_target = 32'h1234_5678;
    apply_stimulus("unwind5", 32'h1234_5678, 1, 0, 1, 1);
    reset = 1'b1;
    apply_stimulus("reset2", 32'h0, 1, 0, 0, 0);

    jump = 1'b1; jump_index = 26'h010003F;
    apply_stimulus("jump_c", 32'h0040_00FC, 1, 0, 0, 0);
    stall = 1'b1; call = 1'b1; jump_index = 26'h0100080;
    apply_stimulus("stall_call1", 32'h0040_00FC, 1, 0, 0, 0);
    stall = 1'b1; call = 1'b1; jump_index = 26'h0100080;
    apply_stimulus("stall_call2", 32'h0040_00FC, 1, 0, 0, 0);
    call = 1'b1; jump_index = 26'h0100080;
    apply_stimulus("call_release", 32'h0040_0200, 0, 0, 0, 0);
    ret = 1'b1; call = 1'b1;
    apply_stimulus("ret_call", 32'h0040_0100, 0, 0, 0, 0);
    ret = 1'b1;
    apply_stimulus("ret_swapped", 32'h0040_0204, 1, 0, 0, 0);
    ret = 1'b1; call = 1'b1; jr_target = 32'h0040_0300;
    apply_stimulus("ret_call_empty", 32'h0040_0300, 0, 0, 0, 0);
    ret = 1'b1;
    apply_stimulus("ret_after_rc", 32'h0040_0208, 1, 0, 0, 0);
    ret = 1'b1; jr_target = 32'h0000_ABC0;
    apply_stimulus("underflow", 32'h0000_ABC0, 1, 0, 0, 1);
    ret = 1'b1; jump = 1'b1; jump_index = 26'h0100000; jr_target = 32'h0000_2000;
    apply_stimulus("ret_over_jump", 32'h0000_2000, 1, 0, 0, 1);
    stall = 1'b1; ret = 1'b1; jr_target = 32'h1111_0000;
    apply_stimulus("stall_ret", 32'h0000_2000, 1, 0, 0, 1);
    reset = 1'b1; stall = 1'b1; call = 1'b1; jump_index = 26'h0100080;
    apply_stimulus("reset_in_stall", 32'h0, 1, 0, 0, 0);
    apply_stimulus("idle_final", 32'h4, 1, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
